// File: rtl/div_req_ctrl_pkg.sv
// Shared types and constants for the divide request controller.
package div_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [OP_W-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [OP_W-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [OP_W-1:0] DIV_OP_REMU = 2'd3;

  localparam logic [XLEN-1:0] XLEN_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [XLEN-1:0] XLEN_ZERO = 32'h0000_0000;
  localparam logic [XLEN-1:0] XLEN_ONE  = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } div_state_t;

  // Two's-complement negation, wrapping mod 2^XLEN.
  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + XLEN_ONE;
  endfunction

endpackage

// File: rtl/div_req_ctrl_if.sv
// Request/response and divider handshake bundle for div_req_ctrl.
// master = the controller, slave = execute stage plus divider.
interface div_req_ctrl_if;
  import div_pkg::*;

  logic            req_vld_i;
  logic            req_rdy_o;
  logic [OP_W-1:0] op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            kill_i;
  logic            rsp_vld_o;
  logic            rsp_rdy_i;
  logic [XLEN-1:0] rsp_data_o;
  logic            div_vld_o;
  logic [XLEN-1:0] div1_o;
  logic [XLEN-1:0] div2_o;
  logic [XLEN-1:0] div_q_i;
  logic [XLEN-1:0] div_r_i;
  logic            div_rdy_i;

  modport master (
    input  req_vld_i, op_i, rs1_i, rs2_i, kill_i, rsp_rdy_i,
    input  div_q_i, div_r_i, div_rdy_i,
    output req_rdy_o, rsp_vld_o, rsp_data_o, div_vld_o, div1_o, div2_o
  );

  modport slave (
    output req_vld_i, op_i, rs1_i, rs2_i, kill_i, rsp_rdy_i,
    output div_q_i, div_r_i, div_rdy_i,
    input  req_rdy_o, rsp_vld_o, rsp_data_o, div_vld_o, div1_o, div2_o
  );

endinterface

// File: rtl/div_req_ctrl_operand_prep.sv
// Operand preparation: magnitudes, result sign flags and the two cases
// (zero divisor, signed overflow) that are answered without the divider.
module div_operand_prep
  import div_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg_q,
  output logic            neg_r,
  output logic            is_rem,
  output logic            special,
  output logic [XLEN-1:0] special_data
);

  logic is_signed_s;

  // Decode the operation into signedness and quotient/remainder selection.
  always_comb begin
    is_signed_s = 1'b0;
    is_rem      = 1'b0;
    case (op)
      DIV_OP_DIV:  begin is_signed_s = 1'b1; is_rem = 1'b0; end
      DIV_OP_DIVU: begin is_signed_s = 1'b0; is_rem = 1'b0; end
      DIV_OP_REM:  begin is_signed_s = 1'b1; is_rem = 1'b1; end
      DIV_OP_REMU: begin is_signed_s = 1'b0; is_rem = 1'b1; end
      default:     begin is_signed_s = 1'b0; is_rem = 1'b0; end
    endcase
  end

  // Magnitudes and sign flags; unsigned ops pass the raw operands through.
  always_comb begin
    neg_q = is_signed_s & (rs1[XLEN-1] ^ rs2[XLEN-1]);
    neg_r = is_signed_s & rs1[XLEN-1];
    if (is_signed_s && rs1[XLEN-1]) mag1 = twos_neg(rs1);
    else                            mag1 = rs1;
    if (is_signed_s && rs2[XLEN-1]) mag2 = twos_neg(rs2);
    else                            mag2 = rs2;
  end

  // Locally resolved cases; the divider must never see a zero divisor.
  always_comb begin
    if (rs2 == XLEN_ZERO) begin
      special = 1'b1;
      if (is_rem) special_data = rs1;
      else        special_data = XLEN_ONES;
    end else if (is_signed_s && (rs1 == INT_MIN) && (rs2 == XLEN_ONES)) begin
      special = 1'b1;
      if (is_rem) special_data = XLEN_ZERO;
      else        special_data = INT_MIN;
    end else begin
      special      = 1'b0;
      special_data = XLEN_ZERO;
    end
  end

endmodule

// File: rtl/div_req_ctrl.sv
// Requester-side controller for the iterative 32-bit unsigned divider.
// One operation outstanding at a time; signed ops are divided as
// magnitudes and sign-corrected on the way back.
module div_req_ctrl
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  div_req_ctrl_if.master bus
);

  div_state_t      state_r;
  logic            req_rdy_r;
  logic            rsp_vld_r;
  logic [XLEN-1:0] rsp_data_r;
  logic            div_vld_r;
  logic [XLEN-1:0] div1_r;
  logic [XLEN-1:0] div2_r;
  logic            is_rem_r;
  logic            neg_q_r;
  logic            neg_r_r;

  logic [XLEN-1:0] mag1_s;
  logic [XLEN-1:0] mag2_s;
  logic            neg_q_s;
  logic            neg_r_s;
  logic            is_rem_s;
  logic            special_s;
  logic [XLEN-1:0] special_data_s;
  logic [XLEN-1:0] result_s;

  div_operand_prep u_prep (
    .op           (bus.op_i),
    .rs1          (bus.rs1_i),
    .rs2          (bus.rs2_i),
    .mag1         (mag1_s),
    .mag2         (mag2_s),
    .neg_q        (neg_q_s),
    .neg_r        (neg_r_s),
    .is_rem       (is_rem_s),
    .special      (special_s),
    .special_data (special_data_s)
  );

  // Sign-correct the divider output for the captured operation.
  always_comb begin
    if (is_rem_r) begin
      if (neg_r_r) result_s = twos_neg(bus.div_r_i);
      else         result_s = bus.div_r_i;
    end else begin
      if (neg_q_r) result_s = twos_neg(bus.div_q_i);
      else         result_s = bus.div_q_i;
    end
  end

  // Control FSM; kill takes priority over divider done and response accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      req_rdy_r  <= 1'b1;
      rsp_vld_r  <= 1'b0;
      rsp_data_r <= XLEN_ZERO;
      div_vld_r  <= 1'b0;
      div1_r     <= XLEN_ZERO;
      div2_r     <= XLEN_ZERO;
      is_rem_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_vld_i && req_rdy_r && !bus.kill_i) begin
            is_rem_r  <= is_rem_s;
            neg_q_r   <= neg_q_s;
            neg_r_r   <= neg_r_s;
            div1_r    <= mag1_s;
            div2_r    <= mag2_s;
            req_rdy_r <= 1'b0;
            if (special_s) begin
              rsp_data_r <= special_data_s;
              rsp_vld_r  <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              div_vld_r <= 1'b1;
              state_r   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // The start pulse goes out even when killed: the divider cannot abort.
          div_vld_r <= 1'b0;
          if (bus.kill_i) state_r <= ST_DRAIN;
          else            state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.kill_i) begin
            state_r <= ST_DRAIN;
          end else if (bus.div_rdy_i) begin
            rsp_data_r <= result_s;
            rsp_vld_r  <= 1'b1;
            state_r    <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (bus.div_rdy_i) begin
            req_rdy_r <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (bus.kill_i || bus.rsp_rdy_i) begin
            rsp_vld_r <= 1'b0;
            req_rdy_r <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          req_rdy_r <= 1'b1;
          rsp_vld_r <= 1'b0;
          div_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy_o  = req_rdy_r;
  assign bus.rsp_vld_o  = rsp_vld_r;
  assign bus.rsp_data_o = rsp_data_r;
  assign bus.div_vld_o  = div_vld_r;
  assign bus.div1_o     = div1_r;
  assign bus.div2_o     = div2_r;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl with a behavioural divider and an
// RV32M reference model for the result.
module tb_div_req_ctrl;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   div_done_cnt;

  // Reference expectations shared with the compare process.
  logic        exp_rsp_ok;
  logic [31:0] exp_data;
  logic [31:0] exp_div1;
  logic [31:0] exp_div2;

  // Divider model state.
  logic        dv_busy;
  int          dv_cnt;

  div_req_ctrl_if bus ();

  div_req_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RV32M semantics written directly from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'd1: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'd2: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    if ((op == 2'd0 || op == 2'd2) && sv < 0) return 32'd0 - v;
    return v;
  endfunction

  // Behavioural divider: 3-cycle minimum latency, single-cycle rdy pulse,
  // result computed from div1/div2 as they stand when it finishes.
  always @(negedge clk) begin
    if (!rst_n) begin
      dv_busy       = 1'b0;
      dv_cnt        = 0;
      bus.div_rdy_i = 1'b0;
      bus.div_q_i   = 32'd0;
      bus.div_r_i   = 32'd0;
    end else begin
      if (bus.div_vld_o && bus.div_rdy_i) check("vld_during_rdy", 32'd1, 32'd0);
      bus.div_rdy_i = 1'b0;
      if (dv_busy) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          dv_busy = 1'b0;
          bus.div_rdy_i = 1'b1;
          div_done_cnt++;
          if (bus.div2_o == 32'd0) begin
            bus.div_q_i = 32'hFFFF_FFFF;
            bus.div_r_i = bus.div1_o;
          end else begin
            bus.div_q_i = bus.div1_o / bus.div2_o;
            bus.div_r_i = bus.div1_o % bus.div2_o;
          end
        end
      end else if (bus.div_vld_o) begin
        check("div2_nonzero", {31'd0, bus.div2_o != 32'd0}, 32'd1);
        dv_busy = 1'b1;
        dv_cnt  = 3;
      end
    end
  end

  // Per-cycle compare of the DUT against the reference expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_vld_o) begin
        check("rsp_allowed", {31'd0, exp_rsp_ok}, 32'd1);
        check("rsp_model", bus.rsp_data_o, exp_data);
        check("rdy_low_in_rsp", {31'd0, bus.req_rdy_o}, 32'd0);
      end
      if (bus.div_vld_o) begin
        check("div1_model", bus.div1_o, exp_div1);
        check("div2_model", bus.div2_o, exp_div2);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_rdy_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_rdy_o) check({nm, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_data      = ref_result(op, a, b);
    exp_div1      = mag(op, a);
    exp_div2      = mag(op, b);
    bus.req_vld_i = 1'b1;
    bus.op_i      = op;
    bus.rs1_i     = a;
    bus.rs2_i     = b;
    @(posedge clk);
    #1;
    bus.req_vld_i = 1'b0;
  endtask

  // One full transaction: issue, measure latency and start pulses,
  // optionally hold off the response, then accept it.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input bit special, input int hold);
    int lat;
    int pulses;
    check({nm, "_model_pin"}, ref_result(op, a, b), lit);
    wait_idle(nm);
    exp_rsp_ok = 1'b1;
    drive_req(op, a, b);
    lat = 1;
    pulses = 0;
    @(negedge clk);
    while (!bus.rsp_vld_o && lat < 100) begin
      if (bus.div_vld_o) pulses++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_rsp_seen"}, {31'd0, bus.rsp_vld_o}, 32'd1);
    if (special) begin
      check({nm, "_latency"}, lat, 32'd1);
      check({nm, "_no_div_vld"}, {31'd0, bus.div_vld_o}, 32'd0);
    end else begin
      check({nm, "_latency_ge5"}, {31'd0, lat >= 5}, 32'd1);
    end
    check({nm, "_pulses"}, pulses, special ? 32'd0 : 32'd1);
    check({nm, "_data"}, bus.rsp_data_o, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold_vld"}, {31'd0, bus.rsp_vld_o}, 32'd1);
      check({nm, "_hold_data"}, bus.rsp_data_o, lit);
      check({nm, "_hold_rdy"}, {31'd0, bus.req_rdy_o}, 32'd0);
    end
    bus.rsp_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_rdy_i = 1'b0;
    exp_rsp_ok = 1'b0;
    @(negedge clk);
    check({nm, "_vld_drop"}, {31'd0, bus.rsp_vld_o}, 32'd0);
    check({nm, "_rdy_back"}, {31'd0, bus.req_rdy_o}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done0;
    int guard;
    total = 0;
    bad = 0;
    div_done_cnt = 0;
    exp_rsp_ok = 1'b0;
    exp_data = 32'd0;
    exp_div1 = 32'd0;
    exp_div2 = 32'd0;
    rst_n = 1'b0;
    bus.req_vld_i = 1'b0;
    bus.op_i = 2'd0;
    bus.rs1_i = 32'd0;
    bus.rs2_i = 32'd0;
    bus.kill_i = 1'b0;
    bus.rsp_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
    check("rst_rsp_vld", {31'd0, bus.rsp_vld_o}, 32'd0);
    check("rst_rsp_data", bus.rsp_data_o, 32'd0);
    check("rst_div_vld", {31'd0, bus.div_vld_o}, 32'd0);
    check("rst_div1", bus.div1_o, 32'd0);
    check("rst_div2", bus.div2_o, 32'd0);
    rst_n = 1'b1;

    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu_by0", 2'd1, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("remu_by0", 2'd3, 32'd100, 32'd0, 32'd100, 1'b1, 0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu_3_10", 2'd1, 32'd3, 32'd10, 32'd0, 1'b0, 0);
    run_op("remu_3_10", 2'd3, 32'd3, 32'd10, 32'd3, 1'b0, 0);

    // Kill one cycle after the start pulse: result discarded, wait for drain.
    wait_idle("kill_wait");
    exp_rsp_ok = 1'b0;
    drive_req(2'd1, 32'd50, 32'd7);
    @(negedge clk);
    check("kill_issue_pulse", {31'd0, bus.div_vld_o}, 32'd1);
    done0 = div_done_cnt;
    @(negedge clk);
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bus.req_rdy_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("kill_rdy_back", {31'd0, bus.req_rdy_o}, 32'd1);
    check("kill_after_div_rdy", {31'd0, div_done_cnt != done0}, 32'd1);
    run_op("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 1'b0, 0);

    run_op("div_bp", 2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 5);

    // Kill while a response is waiting.
    wait_idle("kill_resp");
    exp_rsp_ok = 1'b1;
    drive_req(2'd1, 32'd100, 32'd0);
    @(negedge clk);
    check("kill_resp_vld", {31'd0, bus.rsp_vld_o}, 32'd1);
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    exp_rsp_ok = 1'b0;
    @(negedge clk);
    check("kill_resp_drop", {31'd0, bus.rsp_vld_o}, 32'd0);
    check("kill_resp_rdy", {31'd0, bus.req_rdy_o}, 32'd1);

    // Kill in IDLE blocks acceptance.
    wait_idle("kill_idle");
    bus.kill_i = 1'b1;
    drive_req(2'd1, 32'd5, 32'd1);
    bus.kill_i = 1'b0;
    @(negedge clk);
    check("kill_idle_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
    check("kill_idle_vld", {31'd0, bus.div_vld_o}, 32'd0);
    check("kill_idle_rsp", {31'd0, bus.rsp_vld_o}, 32'd0);

    // Reset while waiting on the divider.
    wait_idle("rst_wait");
    exp_rsp_ok = 1'b0;
    drive_req(2'd1, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_vld", {31'd0, bus.rsp_vld_o}, 32'd0);
    check("midrst_req_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
    check("midrst_div_vld", {31'd0, bus.div_vld_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("remu_after_rst", 2'd3, 32'd3, 32'd10, 32'd3, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
